// File: rtl/jtag_pkg.sv
// ============================================================================
// Module : jtag_pkg
// Brief  : Shared TAP state encodings, opcodes and IR width for the JTAG chain.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package jtag_pkg;

  localparam int IR_W = 4;

  // 1149.1 state encodings; data registers decode these directly.
  localparam logic [3:0] TLR    = 4'hF;
  localparam logic [3:0] RTI    = 4'hC;
  localparam logic [3:0] SEL_DR = 4'h7;
  localparam logic [3:0] CAP_DR = 4'h6;
  localparam logic [3:0] SH_DR  = 4'h2;
  localparam logic [3:0] EX1_DR = 4'h1;
  localparam logic [3:0] PAU_DR = 4'h3;
  localparam logic [3:0] EX2_DR = 4'h0;
  localparam logic [3:0] UPD_DR = 4'h5;
  localparam logic [3:0] SEL_IR = 4'h4;
  localparam logic [3:0] CAP_IR = 4'hE;
  localparam logic [3:0] SH_IR  = 4'hA;
  localparam logic [3:0] EX1_IR = 4'h9;
  localparam logic [3:0] PAU_IR = 4'hB;
  localparam logic [3:0] EX2_IR = 4'h8;
  localparam logic [3:0] UPD_IR = 4'hD;

  localparam logic [IR_W-1:0] IDCODE = 4'b0001;
  localparam logic [IR_W-1:0] BYPASS = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/tap_fsm.sv
// ============================================================================
// Module : tap_fsm
// Brief  : 16-state 1149.1 TAP state register and TMS next-state decode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tap_fsm (
  input  logic       TCK,
  input  logic       TRST_N,
  input  logic       TMS,
  output logic [3:0] tap_state
);
  import jtag_pkg::*;

  logic [3:0] r_state;
  logic [3:0] w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      TLR:     w_next = TMS ? TLR    : RTI;
      RTI:     w_next = TMS ? SEL_DR : RTI;
      SEL_DR:  w_next = TMS ? SEL_IR : CAP_DR;
      CAP_DR:  w_next = TMS ? EX1_DR : SH_DR;
      SH_DR:   w_next = TMS ? EX1_DR : SH_DR;
      EX1_DR:  w_next = TMS ? UPD_DR : PAU_DR;
      PAU_DR:  w_next = TMS ? EX2_DR : PAU_DR;
      EX2_DR:  w_next = TMS ? UPD_DR : SH_DR;
      UPD_DR:  w_next = TMS ? SEL_DR : RTI;
      SEL_IR:  w_next = TMS ? TLR    : CAP_IR;
      CAP_IR:  w_next = TMS ? EX1_IR : SH_IR;
      SH_IR:   w_next = TMS ? EX1_IR : SH_IR;
      EX1_IR:  w_next = TMS ? UPD_IR : PAU_IR;
      PAU_IR:  w_next = TMS ? EX2_IR : PAU_IR;
      EX2_IR:  w_next = TMS ? UPD_IR : SH_IR;
      UPD_IR:  w_next = TMS ? SEL_DR : RTI;
      default: w_next = TLR;
    endcase
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) r_state <= TLR;
    else         r_state <= w_next;
  end

  assign tap_state = r_state;

endmodule

`default_nettype wire

// File: rtl/tap_controller.sv
// ============================================================================
// Module : tap_controller
// Brief  : TAP controller, 4-bit IR, BYPASS register and final TDO mux.
//          JTAG_TDO_NEGEDGE_EN re-times tdo/tdo_en onto the falling TCK edge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tap_controller #(
  parameter int             IR_W       = 4,        // only 4 is supported
  parameter logic [IR_W-1:0] IR_RESET   = 4'b0001,
  parameter logic [IR_W-1:0] IR_CAPTURE = 4'b0101  // LSBs must be 01
) (
  input  logic            TCK,
  input  logic            TRST_N,
  input  logic            TMS,
  input  logic            TDI,
  input  logic            idcode_tdo,
  output logic [3:0]      tap_state,
  output logic [IR_W-1:0] IR,
  output logic            tdo,
  output logic            tdo_en
);
  import jtag_pkg::*;

  logic [IR_W-1:0] r_ir;
  logic [IR_W-1:0] r_ir_shift;
  logic            r_bypass;
  logic            w_tdo;
  logic            w_tdo_en;

  tap_fsm u_tap_fsm (
    .TCK       (TCK),
    .TRST_N    (TRST_N),
    .TMS       (TMS),
    .tap_state (tap_state)
  );

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_ir_shift <= '0;
    end else if (tap_state == CAP_IR) begin
      r_ir_shift <= IR_CAPTURE;
    end else if (tap_state == SH_IR) begin
      r_ir_shift <= {TDI, r_ir_shift[IR_W-1:1]};
    end
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_ir <= IR_RESET;
    end else if (tap_state == TLR) begin
      r_ir <= IR_RESET;
    end else if (tap_state == UPD_IR) begin
      r_ir <= r_ir_shift;
    end
  end

  // Any opcode other than IDCODE routes DR scans through the 1-bit bypass.
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_bypass <= 1'b0;
    end else if (r_ir != IDCODE) begin
      if (tap_state == CAP_DR)     r_bypass <= 1'b0;
      else if (tap_state == SH_DR) r_bypass <= TDI;
    end
  end

  always_comb begin
    w_tdo    = 1'b0;
    w_tdo_en = 1'b0;
    if (tap_state == SH_IR) begin
      w_tdo    = r_ir_shift[0];
      w_tdo_en = 1'b1;
    end else if (tap_state == SH_DR) begin
      w_tdo    = (r_ir == IDCODE) ? idcode_tdo : r_bypass;
      w_tdo_en = 1'b1;
    end
  end

  assign IR = r_ir;

`ifdef JTAG_TDO_NEGEDGE_EN
  logic r_tdo;
  logic r_tdo_en;

  always_ff @(negedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo    <= w_tdo;
      r_tdo_en <= w_tdo_en;
    end
  end

  assign tdo    = r_tdo;
  assign tdo_en = r_tdo_en;
`else
  assign tdo    = w_tdo;
  assign tdo_en = w_tdo_en;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tap_controller.sv
// ============================================================================
// Module : tb_tap_controller
// Brief  : Directed self-checking bench for tap_controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tap_controller;

  localparam logic [3:0] S_TLR = 4'hF, S_RTI = 4'hC, S_SEL_DR = 4'h7, S_CAP_DR = 4'h6;
  localparam logic [3:0] S_SH_DR = 4'h2, S_EX1_DR = 4'h1, S_PAU_DR = 4'h3, S_EX2_DR = 4'h0;
  localparam logic [3:0] S_UPD_DR = 4'h5, S_SEL_IR = 4'h4, S_CAP_IR = 4'hE, S_SH_IR = 4'hA;
  localparam logic [3:0] S_EX1_IR = 4'h9, S_PAU_IR = 4'hB, S_EX2_IR = 4'h8, S_UPD_IR = 4'hD;

  logic       TCK;
  logic       TRST_N;
  logic       TMS;
  logic       TDI;
  logic       idcode_tdo;
  logic [3:0] tap_state;
  logic [3:0] IR;
  logic       tdo;
  logic       tdo_en;

  int n_tests = 0;
  int n_fail  = 0;

  tap_controller dut (
    .TCK        (TCK),
    .TRST_N     (TRST_N),
    .TMS        (TMS),
    .TDI        (TDI),
    .idcode_tdo (idcode_tdo),
    .tap_state  (tap_state),
    .IR         (IR),
    .tdo        (tdo),
    .tdo_en     (tdo_en)
  );

  initial begin
    TCK = 1'b0;
    forever #5 TCK = ~TCK;
  end

`ifdef JTAG_TDO_NEGEDGE_EN
  // tdo may only move while TCK is low (falling edge or async reset).
  always @(tdo) begin
    if ($time > 0) begin
      n_tests++;
      if (TCK !== 1'b0) begin
        n_fail++;
        $display("FAIL tdo_negedge_only: tdo changed to %b with TCK=%b", tdo, TCK);
      end
    end
  end
`endif

  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  task automatic at_neg();
    @(negedge TCK);
    #1;
  endtask

  task automatic load_ir(input logic [3:0] val);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i == 3, val[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    TRST_N = 1'b0; TMS = 1'b1; TDI = 1'b0; idcode_tdo = 1'b0;
    repeat (2) @(posedge TCK);
    #1;
    n_tests++;
    if (tap_state !== S_TLR || IR !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_state: state=%h IR=%b want state=F IR=0001", tap_state, IR);
    end
    n_tests++;
    if (tdo !== 1'b0 || tdo_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tdo: tdo=%b tdo_en=%b want 0 0", tdo, tdo_en);
    end
    at_neg();
    TRST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0);
      n_tests++;
      if (tap_state !== S_TLR) begin
        n_fail++;
        $display("FAIL tlr_hold[%0d]: state=%h want F", i, tap_state);
      end
    end
    step(1'b0, 1'b0);
    n_tests++;
    if (tap_state !== S_RTI) begin
      n_fail++;
      $display("FAIL tlr_to_rti: state=%h want C", tap_state);
    end
  endtask

  task automatic test_ir_capture_load();
    logic [3:0] cap;
    logic [3:0] path [4];
    cap = 4'b0101;
    path[0] = S_SEL_DR; path[1] = S_SEL_IR; path[2] = S_CAP_IR; path[3] = S_SH_IR;
    for (int i = 0; i < 4; i++) begin
      step((i < 2), 1'b0);
      n_tests++;
      if (tap_state !== path[i]) begin
        n_fail++;
        $display("FAIL ir_path[%0d]: state=%h want %h", i, tap_state, path[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      at_neg();
      n_tests++;
      if (tdo !== cap[i] || tdo_en !== 1'b1) begin
        n_fail++;
        $display("FAIL ir_capture_bit[%0d]: tdo=%b tdo_en=%b want %b 1", i, tdo, tdo_en, cap[i]);
      end
      step(i == 3, 1'b1);
    end
    step(1'b1, 1'b0);
    n_tests++;
    if (tap_state !== S_UPD_IR || IR !== 4'b0001) begin
      n_fail++;
      $display("FAIL ir_before_update: state=%h IR=%b want D 0001", tap_state, IR);
    end
    step(1'b0, 1'b0);
    n_tests++;
    if (tap_state !== S_RTI || IR !== 4'b1111) begin
      n_fail++;
      $display("FAIL ir_after_update: state=%h IR=%b want C 1111", tap_state, IR);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    n_tests++;
    if (tap_state !== S_TLR || IR !== 4'b0001) begin
      n_fail++;
      $display("FAIL ir_tlr_restore: state=%h IR=%b want F 0001", tap_state, IR);
    end
  endtask

  task automatic test_bypass();
    logic [3:0] din;
    logic [3:0] dout;
    din  = 4'b1101;  // TDI order 1,0,1,1 (LSB first)
    dout = 4'b1010;  // tdo order 0,1,0,1 (LSB first)
    step(1'b0, 1'b0);
    load_ir(4'b1111);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_tests++;
    if (tap_state !== S_SH_DR || IR !== 4'b1111) begin
      n_fail++;
      $display("FAIL bypass_entry: state=%h IR=%b want 2 1111", tap_state, IR);
    end
    for (int i = 0; i < 4; i++) begin
      at_neg();
      n_tests++;
      if (tdo !== dout[i] || tdo_en !== 1'b1) begin
        n_fail++;
        $display("FAIL bypass_bit[%0d]: tdo=%b tdo_en=%b want %b 1", i, tdo, tdo_en, dout[i]);
      end
      step(i == 3, din[i]);
    end
    step(1'b0, 1'b0);
    at_neg();
    n_tests++;
    if (tap_state !== S_PAU_DR || tdo !== 1'b0 || tdo_en !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_pause: state=%h tdo=%b tdo_en=%b want 3 0 0", tap_state, tdo, tdo_en);
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_idcode();
    logic [3:0] pat;
    pat = 4'b1001;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    n_tests++;
    if (tap_state !== S_SH_DR || IR !== 4'b0001) begin
      n_fail++;
      $display("FAIL idcode_entry: state=%h IR=%b want 2 0001", tap_state, IR);
    end
    for (int i = 0; i < 4; i++) begin
      idcode_tdo = pat[i];
      at_neg();
      n_tests++;
      if (tdo !== pat[i]) begin
        n_fail++;
        $display("FAIL idcode_follow[%0d]: tdo=%b want %b", i, tdo, pat[i]);
      end
      step(i == 3, 1'b0);
    end
    idcode_tdo = 1'b1;
    step(1'b0, 1'b0);
    at_neg();
    n_tests++;
    if (tap_state !== S_PAU_DR || tdo !== 1'b0 || tdo_en !== 1'b0) begin
      n_fail++;
      $display("FAIL idcode_pause: state=%h tdo=%b tdo_en=%b want 3 0 0", tap_state, tdo, tdo_en);
    end
    idcode_tdo = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_shift();
    load_ir(4'b1111);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    at_neg();
    n_tests++;
    if (tap_state !== S_SH_IR || tdo_en !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_shift_setup: state=%h tdo_en=%b want A 1", tap_state, tdo_en);
    end
    TRST_N = 1'b0;
    #1;
    n_tests++;
    if (tap_state !== S_TLR || IR !== 4'b0001 || tdo_en !== 1'b0 || tdo !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_shift_reset: state=%h IR=%b tdo=%b tdo_en=%b want F 0001 0 0",
               tap_state, IR, tdo, tdo_en);
    end
    #2;
    TRST_N = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    n_tests++;
    if (tap_state !== S_TLR || IR !== 4'b0001) begin
      n_fail++;
      $display("FAIL post_reset_tlr: state=%h IR=%b want F 0001", tap_state, IR);
    end
  endtask

  task automatic test_state_walk();
    logic       tms [20];
    logic [3:0] exp [20];
    tms = '{0, 1, 0, 0, 1, 0, 1, 1, 1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 0};
    exp = '{S_RTI, S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAU_DR, S_EX2_DR, S_UPD_DR,
            S_SEL_DR, S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAU_IR, S_EX2_IR, S_UPD_IR,
            S_SEL_DR, S_SEL_IR, S_TLR, S_RTI};
    for (int i = 0; i < 20; i++) begin
      step(tms[i], 1'b0);
      n_tests++;
      if (tap_state !== exp[i]) begin
        n_fail++;
        $display("FAIL walk[%0d]: state=%h want %h", i, tap_state, exp[i]);
      end
    end
    // EX2_DR loops back to SH_DR on TMS=0.
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    n_tests++;
    if (tap_state !== S_SH_DR) begin
      n_fail++;
      $display("FAIL ex2_to_shift: state=%h want 2", tap_state);
    end
  endtask

  initial begin
    test_reset();
    test_ir_capture_load();
    test_bypass();
    test_idcode();
    test_reset_mid_shift();
    test_state_walk();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
